rs_issue_arbiter: RTL and testbench



---
 rtl/rs_issue_arbiter_if.sv | 32 +++
 rtl/rs_issue_arbiter.sv | 128 ++++++++++++
 tb/tb_rs_issue_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/rs_issue_arbiter_if.sv
// Issue-side bundle for one reservation station: allocation lanes, per-slot readiness,
// the FU valid/ready handshake, slot return and occupancy. master = arbiter, slave = RS/FU side.
interface rs_issue_arbiter_if #(
    parameter int NUM_RS_ENTRIES = 8
);
    localparam int IW = $clog2(NUM_RS_ENTRIES);

    logic                      flush;
    logic                      alloc_valid_0;
    logic [IW-1:0]             alloc_idx_0;
    logic                      alloc_valid_1;
    logic [IW-1:0]             alloc_idx_1;
    logic [NUM_RS_ENTRIES-1:0] entry_ready;
    logic                      issue_valid;
    logic [IW-1:0]             issue_idx;
    logic                      issue_ready;
    logic                      issue_free_valid;
    logic [IW:0]               issue_free;
    logic [IW:0]               occupancy;

    modport master (
        input  flush, alloc_valid_0, alloc_idx_0, alloc_valid_1, alloc_idx_1,
               entry_ready, issue_ready,
        output issue_valid, issue_idx, issue_free_valid, issue_free, occupancy
    );

    modport slave (
        output flush, alloc_valid_0, alloc_idx_0, alloc_valid_1, alloc_idx_1,
               entry_ready, issue_ready,
        input  issue_valid, issue_idx, issue_free_valid, issue_free, occupancy
    );
endinterface

// File: rtl/rs_issue_arbiter.sv
// Reservation-station issue scheduler: picks one ready occupied slot per cycle for the FU and
// returns fired slots to the free list. RS_AGE_ORDER_EN selects oldest-first, else lowest index.
module rs_issue_arbiter #(
    parameter int NUM_RS_ENTRIES = 8,
    parameter int TYPE           = 0
) (
    input logic             clk,
    input logic             rst_n,
    rs_issue_arbiter_if.master bus
);
    localparam int N  = NUM_RS_ENTRIES;
    localparam int IW = $clog2(N);

    if (TYPE < 0 || TYPE > 2 || N < 2 || (N & (N - 1)) != 0) begin : g_bad_cfg
        $error("rs_issue_arbiter: unsupported TYPE or NUM_RS_ENTRIES");
    end

    logic [N-1:0]  occ;
    logic [N-1:0]  alloc_oh;
    logic [N-1:0]  pres_oh;
    logic [N-1:0]  cand;
    logic [IW:0]   occ_cnt;
    logic [IW:0]   alloc_cnt;
    logic          iv;
    logic [IW-1:0] iidx;
    logic          fv;
    logic [IW:0]   fidx;
    logic          fire;
    logic          sel_any;
    logic [IW-1:0] sel_idx;

    assign fire      = iv & bus.issue_ready;
    assign alloc_cnt = (IW+1)'(bus.alloc_valid_0) + (IW+1)'(bus.alloc_valid_1);

    always_comb begin
        alloc_oh = '0;
        pres_oh  = '0;
        if (bus.alloc_valid_0) alloc_oh[bus.alloc_idx_0] = 1'b1;
        if (bus.alloc_valid_1) alloc_oh[bus.alloc_idx_1] = 1'b1;
        if (iv)                pres_oh[iidx]             = 1'b1;
    end

    // The presented slot is never a candidate: it is either held or leaving this edge.
    assign cand    = occ & bus.entry_ready & ~pres_oh;
    assign sel_any = |cand;

`ifdef RS_AGE_ORDER_EN
    logic [N-1:0][N-1:0] older;
    logic [N-1:0][N-1:0] older_nxt;
    logic [N-1:0]        sel_oh;

    // A new slot is younger than everything occupied now; lane 0 beats lane 1 on a tie.
    always_comb begin
        older_nxt = older;
        if (bus.alloc_valid_0) begin
            for (int j = 0; j < N; j++) begin
                older_nxt[bus.alloc_idx_0][j] = 1'b0;
                older_nxt[j][bus.alloc_idx_0] = occ[j];
            end
        end
        if (bus.alloc_valid_1) begin
            for (int j = 0; j < N; j++) begin
                older_nxt[bus.alloc_idx_1][j] = 1'b0;
                older_nxt[j][bus.alloc_idx_1] = occ[j];
            end
        end
        if (bus.alloc_valid_0 && bus.alloc_valid_1) begin
            older_nxt[bus.alloc_idx_0][bus.alloc_idx_1] = 1'b1;
            older_nxt[bus.alloc_idx_1][bus.alloc_idx_0] = 1'b0;
        end
    end

    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            sel_oh[i] = cand[i];
            for (int j = 0; j < N; j++)
                if (cand[j] && older[j][i]) sel_oh[i] = 1'b0;
        end
        for (int i = 0; i < N; i++)
            if (sel_oh[i]) sel_idx = sel_idx | IW'(i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         older <= '0;
        else if (bus.flush) older <= '0;
        else                older <= older_nxt;
    end
`else
    always_comb begin
        sel_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (cand[i]) sel_idx = IW'(i);
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ     <= '0;
            occ_cnt <= '0;
            iv      <= 1'b0;
            iidx    <= '0;
            fv      <= 1'b0;
            fidx    <= '0;
        end else if (bus.flush) begin
            occ     <= '0;
            occ_cnt <= '0;
            iv      <= 1'b0;
            fv      <= 1'b0;
        end else begin
            occ     <= (occ & ~(pres_oh & {N{fire}})) | alloc_oh;
            occ_cnt <= occ_cnt + alloc_cnt - (IW+1)'(fire);
            fv      <= fire;
            if (fire) fidx <= {1'b0, iidx};
            if (!iv || fire) begin
                iv <= sel_any;
                if (sel_any) iidx <= sel_idx;
            end
        end
    end

    assign bus.issue_valid      = iv;
    assign bus.issue_idx        = iidx;
    assign bus.issue_free_valid = fv;
    assign bus.issue_free       = fidx;
    assign bus.occupancy        = occ_cnt;
endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Scoreboard bench for rs_issue_arbiter: expected issue order is queued as stimulus is driven
// and popped on every observed fire; the slot-return pulse is checked the cycle after each fire.
module tb_rs_issue_arbiter;
    localparam int N  = 8;
    localparam int IW = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    bit   free_due = 1'b0;
    int   free_exp = 0;

    rs_issue_arbiter_if #(.NUM_RS_ENTRIES(N)) bus ();

    rs_issue_arbiter #(.NUM_RS_ENTRIES(N), .TYPE(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic alloc(input logic v0, input int i0, input logic v1, input int i1);
        bus.alloc_valid_0 = v0;
        bus.alloc_idx_0   = IW'(i0);
        bus.alloc_valid_1 = v1;
        bus.alloc_idx_1   = IW'(i1);
    endtask

    // Monitor on the falling edge: inputs are stable, so a fire seen here happens at the next rise.
    always @(negedge clk) begin
        if (rst_n) begin
            if (free_due) begin
                chk("free_valid", int'(bus.issue_free_valid), 1);
                chk("issue_free", int'(bus.issue_free), free_exp);
            end else begin
                chk("free_idle", int'(bus.issue_free_valid), 0);
            end
            free_due = 1'b0;
            if (bus.issue_valid && bus.issue_ready && !bus.flush) begin
                chk("sb_pending", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) chk("issue_order", int'(bus.issue_idx), exp_q.pop_front());
                free_due = 1'b1;
                free_exp = int'(bus.issue_idx);
            end
        end
    end

    initial begin
        bus.flush       = 1'b0;
        bus.entry_ready = '0;
        bus.issue_ready = 1'b0;
        alloc(0, 0, 0, 0);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_valid", int'(bus.issue_valid), 0);
        chk("rst_idx", int'(bus.issue_idx), 0);
        chk("rst_free_valid", int'(bus.issue_free_valid), 0);
        chk("rst_free", int'(bus.issue_free), 0);
        chk("rst_occ", int'(bus.occupancy), 0);
        step();
        rst_n = 1'b1;
        step();

        // Two lanes in one cycle, both ready: 3 then 5.
        bus.entry_ready = 8'b0010_1000;
        bus.issue_ready = 1'b1;
        alloc(1, 3, 1, 5);
        exp_q.push_back(3);
        exp_q.push_back(5);
        step();
        alloc(0, 0, 0, 0);
        chk("t1_occ2", int'(bus.occupancy), 2);
        chk("t1_nvalid", int'(bus.issue_valid), 0);
        step();
        chk("t1_idx3", int'(bus.issue_idx), 3);
        chk("t1_occ2b", int'(bus.occupancy), 2);
        step();
        chk("t1_idx5", int'(bus.issue_idx), 5);
        chk("t1_occ1", int'(bus.occupancy), 1);
        step();
        chk("t1_empty", int'(bus.issue_valid), 0);
        chk("t1_occ0", int'(bus.occupancy), 0);
        step();

        // Age vs fixed priority: allocate 6 then 1, make both ready together.
        bus.entry_ready = '0;
        alloc(1, 6, 0, 0);
        step();
        alloc(1, 1, 0, 0);
        step();
        alloc(0, 0, 0, 0);
        bus.entry_ready = 8'b0100_0010;
`ifdef RS_AGE_ORDER_EN
        exp_q.push_back(6);
        exp_q.push_back(1);
`else
        exp_q.push_back(1);
        exp_q.push_back(6);
`endif
        step();
        chk("t2_first_valid", int'(bus.issue_valid), 1);
        step();
        chk("t2_second_valid", int'(bus.issue_valid), 1);
        step();
        chk("t2_empty", int'(bus.issue_valid), 0);
        step();

        // Back-pressure: slot 2 held 4 cycles while slot 0 becomes ready and 2 drops ready.
        bus.issue_ready = 1'b0;
        bus.entry_ready = 8'b0000_0100;
        alloc(1, 2, 0, 0);
        step();
        alloc(1, 0, 0, 0);
        step();
        alloc(0, 0, 0, 0);
        bus.entry_ready = 8'b0000_0001;
        for (int k = 0; k < 4; k++) begin
            chk("t3_hold_valid", int'(bus.issue_valid), 1);
            chk("t3_hold_idx", int'(bus.issue_idx), 2);
            step();
        end
        exp_q.push_back(2);
        exp_q.push_back(0);
        bus.issue_ready = 1'b1;
        step();
        chk("t3_next_idx", int'(bus.issue_idx), 0);
        chk("t3_next_valid", int'(bus.issue_valid), 1);
        step();
        chk("t3_empty", int'(bus.issue_valid), 0);
        step();

        // Fill all slots in reverse order, then drain at one issue per cycle.
        bus.entry_ready = '0;
        alloc(1, 7, 1, 6);
        step();
        alloc(1, 5, 1, 4);
        step();
        alloc(1, 3, 1, 2);
        step();
        alloc(1, 1, 1, 0);
        step();
        alloc(0, 0, 0, 0);
        chk("t4_full", int'(bus.occupancy), N);
        for (int k = 0; k < N; k++) begin
`ifdef RS_AGE_ORDER_EN
            exp_q.push_back(N - 1 - k);
`else
            exp_q.push_back(k);
`endif
        end
        bus.entry_ready = '1;
        step();
        for (int k = 0; k < N; k++) begin
            chk("t4_no_bubble", int'(bus.issue_valid), 1);
            chk("t4_occ", int'(bus.occupancy), N - k);
            step();
        end
        chk("t4_empty", int'(bus.issue_valid), 0);
        chk("t4_occ0", int'(bus.occupancy), 0);
        step();

        // Flush with 4 occupied and a slot presented; flush beats the fire.
        bus.issue_ready = 1'b0;
        alloc(1, 0, 1, 1);
        step();
        alloc(1, 2, 1, 3);
        step();
        alloc(0, 0, 0, 0);
        chk("t5_occ4", int'(bus.occupancy), 4);
        step();
        chk("t5_pres", int'(bus.issue_valid), 1);
        bus.flush       = 1'b1;
        bus.issue_ready = 1'b1;
        step();
        bus.flush = 1'b0;
        chk("t5_fl_valid", int'(bus.issue_valid), 0);
        chk("t5_fl_occ", int'(bus.occupancy), 0);
        chk("t5_fl_nofree", int'(bus.issue_free_valid), 0);
        alloc(1, 0, 0, 0);
        exp_q.push_back(0);
        step();
        alloc(0, 0, 0, 0);
        step();
        chk("t5_re_valid", int'(bus.issue_valid), 1);
        chk("t5_re_idx", int'(bus.issue_idx), 0);
        step();
        chk("t5_re_occ", int'(bus.occupancy), 0);
        step();

        // Async reset while a free pulse is on the outputs.
        alloc(1, 4, 0, 0);
        exp_q.push_back(4);
        step();
        alloc(0, 0, 0, 0);
        step();
        step();
        chk("t6_pending", int'(bus.issue_free_valid), 1);
        #2 rst_n = 1'b0;
        free_due = 1'b0;
        #1;
        chk("t6_rst_valid", int'(bus.issue_valid), 0);
        chk("t6_rst_idx", int'(bus.issue_idx), 0);
        chk("t6_rst_free_valid", int'(bus.issue_free_valid), 0);
        chk("t6_rst_free", int'(bus.issue_free), 0);
        chk("t6_rst_occ", int'(bus.occupancy), 0);
        step();
        rst_n = 1'b1;
        alloc(1, 5, 0, 0);
        exp_q.push_back(5);
        step();
        alloc(0, 0, 0, 0);
        chk("t6_occ1", int'(bus.occupancy), 1);
        step();
        chk("t6_idx5", int'(bus.issue_idx), 5);
        step();
        chk("t6_occ0", int'(bus.occupancy), 0);

        repeat (3) step();
        chk("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
